uart_alu_ctrl: RTL and testbench
================================

Name: uart_alu_ctrl

Overview:
Frame sequencer between the UART receiver, the ALU and the UART transmitter.
- Collects three received bytes in order: operand A, operand B, opcode.
- Drives the ALU with the captured values and captures the ALU result.
- Hands the result to the TX block with a start/done handshake.
- Supervises inter-byte timeout and opcode validity, and reports errors.

Parameters:
NB_DATA, 8, data/operand/result width in bits (one UART byte)
NB_OP, 6, opcode width; taken from i_rx_data[NB_OP-1:0], upper bits ignored
TIMEOUT_TICKS, 2048, i_tick count allowed between bytes of one frame (16 ticks/bit, so ~12.8 byte times)

Ports:
clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_tick  in  1  baud oversampling tick (same tick as RX/TX)
i_rx_done  in  1  one-cycle pulse: i_rx_data valid
i_rx_data  in  NB_DATA  received byte
i_alu_result  in  NB_DATA  combinational ALU output
i_tx_done  in  1  one-cycle pulse: TX finished stop bit
o_data_a  out  NB_DATA  ALU operand A (registered)
o_data_b  out  NB_DATA  ALU operand B (registered)
o_op  out  NB_OP  ALU opcode (registered)
o_tx_start  out  1  one-cycle pulse requesting transmission
o_tx_data  out  NB_DATA  byte to transmit (registered)
o_busy  out  1  high in any state except GET_A
o_err  out  1  one-cycle error pulse
o_err_code  out  2  last error: 0 none, 1 timeout, 2 bad opcode, 3 overrun; held until next frame completes OK

Behaviour:
- Reset (async, i_rst_n=0): state=GET_A; all outputs 0; timeout counter 0. Reset mid-frame discards partial frame; no TX issued.
- States (one-hot localparams): GET_A, GET_B, GET_OP, EXEC, SEND, WAIT_TX.
- GET_A: on i_rx_done, o_data_a<=i_rx_data, clear timeout counter, go GET_B.
- GET_B: on i_rx_done, o_data_b<=i_rx_data, clear counter, go GET_OP.
- GET_OP: on i_rx_done, o_op<=i_rx_data[NB_OP-1:0].
  - Valid opcode -> EXEC.
  - Invalid opcode -> o_err pulse, o_err_code<=2, go GET_A.
- Timeout (GET_B, GET_OP only): counter increments on i_tick; clears on each i_rx_done.
  - When counter reaches TIMEOUT_TICKS-1 and another i_tick arrives with no i_rx_done that cycle: o_err pulse, o_err_code<=1, go GET_A.
  - i_rx_done and the expiring tick in the same cycle: byte wins, no error.
- EXEC: exactly one cycle; o_tx_data<=i_alu_result (operands stable since prior cycle); go SEND.
- SEND: o_tx_start=1 for exactly one cycle; go WAIT_TX.
- WAIT_TX: hold o_tx_data; on i_tx_done, o_err_code<=0, go GET_A.
  - i_tx_done in any other state is ignored.
- Overrun: i_rx_done in EXEC/SEND/WAIT_TX -> byte dropped, o_err pulse, o_err_code<=3; sequencing continues unaffected.
- Latency: last i_rx_done (opcode) at cycle N -> o_tx_start at cycle N+2.
- Operand/opcode registers hold their value until overwritten by the next frame.
- Timeout counter width = clog2(TIMEOUT_TICKS); saturates, never wraps.
- No timeout in GET_A (idle line is legal indefinitely).
- No timeout in WAIT_TX (TX done is guaranteed).

Decomposition:
- Shared package (uart_pkg): opcode constants ADD=6'b100000, SUB=6'b100010, AND=6'b100100, OR=6'b100101, XOR=6'b100110, NOR=6'b100111, SRA=6'b000011, SRL=6'b000010; error-code constants; state encodings; clog2 function.
- Sub-module: uart_timeout_cnt (tick counter with clear/enable/expire), also reusable by RX for framing watchdog.
- Opcode validity check is a combinational function in the package.

Test Plan:
- Frame 0x05, 0x03, 0x20 (ADD), ALU model returns 0x08 -> o_data_a=0x05, o_data_b=0x03, o_op=0x20; o_tx_start 2 cycles after 3rd rx_done; o_tx_data=0x08; after i_tx_done, o_busy=0, o_err_code=0.
- Frame 0x0F, 0x01, 0x3F (invalid) -> o_err pulse, o_err_code=2, no o_tx_start, state back to GET_A (o_busy=0).
- Send 0x11, then 2048 ticks with no byte -> o_err pulse, o_err_code=1, o_busy=0; next byte 0x22 is captured as operand A.
- rx_done coincident with 2048th tick in GET_B -> no error, byte captured as B.
- Extra byte 0xAA during WAIT_TX -> o_err_code=3, o_tx_data unchanged, o_tx_start not repeated; i_tx_done returns to GET_A.
- Assert i_rst_n=0 mid-GET_OP -> all outputs 0 immediately; after release, a full ADD frame 0x01, 0x01, 0x20 produces o_tx_data=0x02.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART/ALU frame path: default widths, ALU opcodes,
// error codes, sequencer states and small helper functions.
package uart_pkg;

    localparam int unsigned NB_DATA_DEF       = 8;
    localparam int unsigned NB_OP_DEF         = 6;
    localparam int unsigned TIMEOUT_TICKS_DEF = 2048;

    localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_BAD_OP  = 2'd2;
    localparam logic [1:0] ERR_OVERRUN = 2'd3;

    // One-hot sequencer states.
    typedef enum logic [5:0] {
        ST_GET_A   = 6'b000001,
        ST_GET_B   = 6'b000010,
        ST_GET_OP  = 6'b000100,
        ST_EXEC    = 6'b001000,
        ST_SEND    = 6'b010000,
        ST_WAIT_TX = 6'b100000
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic logic op_valid(input logic [NB_OP_DEF-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Saturating tick watchdog: counts i_tick while enabled and flags the tick that
// would exceed TICKS-1. A clear in the same cycle suppresses the expiry.
module uart_timeout_cnt
    import uart_pkg::*;
#(
    parameter int unsigned TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_tick,
    output logic o_expire_c
);

    localparam int unsigned   CW   = (clog2(TICKS) > 0) ? clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr || !i_en) begin
            cnt_d = '0;
        end else if (i_tick && !at_last) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expire_c = i_en & i_tick & ~i_clr & at_last;

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer: gathers operand A, operand B and opcode from the UART RX,
// drives the ALU, and hands the result to the UART TX with error supervision.
module uart_alu_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned NB_DATA       = NB_DATA_DEF,
    parameter int unsigned NB_OP         = NB_OP_DEF,
    parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_err,
    output logic [1:0]         o_err_code
);

    state_e     state_q;
    logic       tmo_en;
    logic       tmo_expire_c;
    logic       op_ok;
    logic       in_tx_phase;

    assign tmo_en      = (state_q == ST_GET_B) || (state_q == ST_GET_OP);
    assign op_ok       = op_valid(NB_OP_DEF'(i_rx_data[NB_OP-1:0]));
    assign in_tx_phase = (state_q == ST_EXEC) || (state_q == ST_SEND) || (state_q == ST_WAIT_TX);

    uart_timeout_cnt #(
        .TICKS (TIMEOUT_TICKS)
    ) u_timeout (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (i_rx_done),
        .i_en       (tmo_en),
        .i_tick     (i_tick),
        .o_expire_c (tmo_expire_c)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_GET_A;
            o_data_a   <= '0;
            o_data_b   <= '0;
            o_op       <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
            o_err_code <= ERR_NONE;
        end else begin
            o_tx_start <= 1'b0;
            o_err      <= 1'b0;
            case (state_q)
                ST_GET_A: begin
                    if (i_rx_done) begin
                        o_data_a <= i_rx_data;
                        o_busy   <= 1'b1;
                        state_q  <= ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    if (i_rx_done) begin
                        o_data_b <= i_rx_data;
                        state_q  <= ST_GET_OP;
                    end else if (tmo_expire_c) begin
                        o_err      <= 1'b1;
                        o_err_code <= ERR_TIMEOUT;
                        o_busy     <= 1'b0;
                        state_q    <= ST_GET_A;
                    end
                end
                ST_GET_OP: begin
                    if (i_rx_done) begin
                        o_op <= i_rx_data[NB_OP-1:0];
                        if (op_ok) begin
                            state_q <= ST_EXEC;
                        end else begin
                            o_err      <= 1'b1;
                            o_err_code <= ERR_BAD_OP;
                            o_busy     <= 1'b0;
                            state_q    <= ST_GET_A;
                        end
                    end else if (tmo_expire_c) begin
                        o_err      <= 1'b1;
                        o_err_code <= ERR_TIMEOUT;
                        o_busy     <= 1'b0;
                        state_q    <= ST_GET_A;
                    end
                end
                // Operands were registered last cycle, so the ALU output is settled here.
                ST_EXEC: begin
                    o_tx_data  <= i_alu_result;
                    o_tx_start <= 1'b1;
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
                    state_q <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        o_err_code <= ERR_NONE;
                        o_busy     <= 1'b0;
                        state_q    <= ST_GET_A;
                    end
                end
                default: begin
                    o_busy  <= 1'b0;
                    state_q <= ST_GET_A;
                end
            endcase
            // Bytes arriving while a result is in flight are dropped but reported.
            if (i_rx_done && in_tx_phase) begin
                o_err      <= 1'b1;
                o_err_code <= ERR_OVERRUN;
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Randomized self-checking bench for uart_alu_ctrl against a frame-level
// reference model with a behavioural ALU stub.
module tb_uart_alu_ctrl;

    localparam int unsigned TICKS = 2048;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       i_tick;
    logic       i_rx_done;
    logic [7:0] i_rx_data;
    logic [7:0] i_alu_result;
    logic       i_tx_done;
    logic [7:0] o_data_a;
    logic [7:0] o_data_b;
    logic [5:0] o_op;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic       o_busy;
    logic       o_err;
    logic [1:0] o_err_code;

    int checks      = 0;
    int errors      = 0;
    int err_pulses  = 0;
    int start_cnt   = 0;
    int exp_err     = 0;
    int exp_starts  = 0;
    logic [1:0] exp_code = 2'd0;
    logic [7:0] last_tx  = 8'h00;

    logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

    always #5 clk = ~clk;

    uart_alu_ctrl #(
        .NB_DATA       (8),
        .NB_OP         (6),
        .TIMEOUT_TICKS (TICKS)
    ) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_tick       (i_tick),
        .i_rx_done    (i_rx_done),
        .i_rx_data    (i_rx_data),
        .i_alu_result (i_alu_result),
        .i_tx_done    (i_tx_done),
        .o_data_a     (o_data_a),
        .o_data_b     (o_data_b),
        .o_op         (o_op),
        .o_tx_start   (o_tx_start),
        .o_tx_data    (o_tx_data),
        .o_busy       (o_busy),
        .o_err        (o_err),
        .o_err_code   (o_err_code)
    );

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return $signed(a) >>> b;
            6'h02:   return a >> b;
            default: return 8'hEE;
        endcase
    endfunction

    // Environment ALU: combinational from the operands the DUT presents.
    always_comb i_alu_result = alu_model(o_data_a, o_data_b, o_op);

    always @(negedge clk) begin
        if (o_err)      err_pulses++;
        if (o_tx_start) start_cnt++;
    end

    function automatic logic op_ok(input logic [5:0] op);
        for (int i = 0; i < 8; i++) if (valid_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic tk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        i_tick    = tk;
        step();
        i_rx_done = 1'b0;
        i_tick    = 1'b0;
    endtask

    task automatic idle(input int n, input logic tk);
        for (int i = 0; i < n; i++) begin
            i_tick = tk;
            step();
        end
        i_tick = 1'b0;
    endtask

    task automatic idle_rand(input int n);
        for (int i = 0; i < n; i++) begin
            i_tick = 1'($urandom_range(0, 1));
            step();
        end
        i_tick = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"},    o_data_a,   0);
        check({tag, "_b"},    o_data_b,   0);
        check({tag, "_op"},   o_op,       0);
        check({tag, "_st"},   o_tx_start, 0);
        check({tag, "_tx"},   o_tx_data,  0);
        check({tag, "_busy"}, o_busy,     0);
        check({tag, "_err"},  o_err,      0);
        check({tag, "_code"}, o_err_code, 0);
    endtask

    // Opcode byte onward: ovr 0 none, 1 extra byte during SEND, 2 during WAIT_TX.
    task automatic finish_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opbyte,
                             input int ovr, input logic [7:0] ob);
        logic [5:0] op;
        logic [7:0] exp_tx;
        op = opbyte[5:0];
        send_byte(opbyte, 1'($urandom_range(0, 1)));
        check("op", o_op, op);
        check("hold_a", o_data_a, a);
        check("hold_b", o_data_b, b);
        if (op_ok(op)) begin
            exp_tx = alu_model(a, b, op);
            check("exec_start", o_tx_start, 0);
            check("exec_err", o_err, 0);
            step();
            exp_starts++;
            check("start", o_tx_start, 1);
            check("tx_data", o_tx_data, exp_tx);
            check("send_busy", o_busy, 1);
            if (ovr == 1) send_byte(ob, 1'b0);
            else step();
            check("start_once", o_tx_start, 0);
            if (ovr == 2) begin
                idle($urandom_range(0, 3), 1'b0);
                send_byte(ob, 1'b0);
            end
            if (ovr != 0) begin
                exp_err++;
                exp_code = 2'd3;
                check("ovr_err", o_err, 1);
                check("ovr_code", o_err_code, exp_code);
                check("ovr_tx", o_tx_data, exp_tx);
            end
            idle($urandom_range(0, 4), 1'($urandom_range(0, 1)));
            check("wait_busy", o_busy, 1);
            check("wait_start", o_tx_start, 0);
            i_tx_done = 1'b1;
            step();
            i_tx_done = 1'b0;
            exp_code  = 2'd0;
            last_tx   = exp_tx;
            check("done_busy", o_busy, 0);
            check("done_code", o_err_code, exp_code);
            check("done_tx", o_tx_data, exp_tx);
            check("done_err", o_err, 0);
        end else begin
            exp_err++;
            exp_code = 2'd2;
            check("bad_err", o_err, 1);
            check("bad_code", o_err_code, exp_code);
            check("bad_busy", o_busy, 0);
            check("bad_start", o_tx_start, 0);
            check("bad_tx", o_tx_data, last_tx);
            step();
        end
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opbyte,
                             input int ovr, input logic [7:0] ob);
        send_byte(a, 1'($urandom_range(0, 1)));
        check("cap_a", o_data_a, a);
        check("busy_a", o_busy, 1);
        idle_rand($urandom_range(0, 6));
        send_byte(b, 1'($urandom_range(0, 1)));
        check("cap_b", o_data_b, b);
        idle_rand($urandom_range(0, 6));
        finish_op(a, b, opbyte, ovr, ob);
    endtask

    initial begin
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] opbyte;

        i_rst_n   = 1'b0;
        i_tick    = 1'b0;
        i_rx_done = 1'b0;
        i_rx_data = 8'h00;
        i_tx_done = 1'b0;
        #3;
        check_all_zero("reset");
        step();
        step();
        i_rst_n = 1'b1;
        step();

        // Basic ADD frame.
        run_frame(8'h05, 8'h03, 8'h20, 0, 8'h00);
        check("plan_add_tx", o_tx_data, 8'h08);
        check("plan_add_op", o_op, 6'h20);

        // Invalid opcode.
        run_frame(8'h0F, 8'h01, 8'h3F, 0, 8'h00);
        check("plan_bad_code", o_err_code, 2'd2);

        // tx_done outside WAIT_TX is ignored.
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        check("txd_idle_busy", o_busy, 0);
        check("txd_idle_code", o_err_code, exp_code);

        // Timeout in GET_B, then recovery with a fresh operand A.
        send_byte(8'h11, 1'b0);
        idle(TICKS - 1, 1'b1);
        check("to_pre_err", o_err, 0);
        check("to_pre_busy", o_busy, 1);
        idle(1, 1'b1);
        exp_err++;
        exp_code = 2'd1;
        check("to_err", o_err, 1);
        check("to_code", o_err_code, exp_code);
        check("to_busy", o_busy, 0);
        send_byte(8'h22, 1'b0);
        check("to_next_a", o_data_a, 8'h22);
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        check("txd_getb_busy", o_busy, 1);
        send_byte(8'h07, 1'b0);
        finish_op(8'h22, 8'h07, 8'h22, 0, 8'h00);

        // Byte coincident with the expiring tick wins.
        send_byte(8'h33, 1'b0);
        idle(TICKS - 1, 1'b1);
        send_byte(8'h44, 1'b1);
        check("coin_err", o_err, 0);
        check("coin_b", o_data_b, 8'h44);
        check("coin_busy", o_busy, 1);
        finish_op(8'h33, 8'h44, 8'h25, 0, 8'h00);

        // Timeout in GET_OP.
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        idle(TICKS - 1, 1'b1);
        check("top_pre_err", o_err, 0);
        idle(1, 1'b1);
        exp_err++;
        exp_code = 2'd1;
        check("top_err", o_err, 1);
        check("top_code", o_err_code, exp_code);
        check("top_busy", o_busy, 0);

        // Overrun during WAIT_TX.
        run_frame(8'h09, 8'h04, 8'h22, 2, 8'hAA);

        // Reset in the middle of GET_OP.
        send_byte(8'h77, 1'b0);
        send_byte(8'h66, 1'b0);
        #2;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("mid_rst");
        exp_code = 2'd0;
        last_tx  = 8'h00;
        step();
        i_rst_n = 1'b1;
        step();
        run_frame(8'h01, 8'h01, 8'h20, 0, 8'h00);
        check("rst_add_tx", o_tx_data, 8'h02);

        // Randomized frames.
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                op = valid_ops[$urandom_range(0, 7)];
            end else begin
                do op = 6'($urandom_range(0, 63)); while (op_ok(op));
            end
            opbyte = {2'($urandom_range(0, 3)), op};
            run_frame(a, b, opbyte, int'($urandom_range(0, 2)), 8'($urandom));
        end

        idle(2, 1'b0);
        check("err_pulses", err_pulses, exp_err);
        check("tx_starts", start_cnt, exp_starts);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
